// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the video capture engine.
// Pixels are stored as 32-bit words with an 8-bit zero pad above the RGB triple.
package vga_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_CAPT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERROR = 3'd4
  } cap_state_e;

  localparam logic [7:0] PIX_PAD = 8'h00;
  localparam int         PIX_W   = 32;

  function automatic logic [PIX_W-1:0] pix_word(input logic [23:0] rgb);
    return {PIX_PAD, rgb};
  endfunction

endpackage

// File: rtl/vga_capture_fifo.sv
// Single-clock first-word-fall-through FIFO with async reset and sync clear.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module vga_capture_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] dat_i,
  output logic [DW-1:0] dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   cnt_o
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = cnt_q[AW];
  assign cnt_o   = cnt_q;
  assign dat_o   = mem_q[rp_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= dat_i;
  end

endmodule

// File: rtl/vga_capture.sv
// Video capture engine: samples a synchronous pixel stream and writes active
// pixels linearly from a programmable base address as a Wishbone master.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int   FIFO_AWIDTH = 4,
  parameter logic ARST_LVL    = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        rst_i,
  input  logic        wb_rst_i,
  input  logic        ctrl_cen,
  input  logic        ctrl_csm,
  input  logic        ctrl_vsl,
  input  logic        ctrl_bl,
  input  logic [29:0] CBAR,
  input  logic        pix_en_i,
  input  logic        vsync_i,
  input  logic        blank_i,
  input  logic [23:0] rgb_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  output logic        wbm_cab_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        stat_busy,
  output logic        eof,
  output logic        ovint,
  output logic        sint
);
  localparam int CW = FIFO_AWIDTH + 1;

  cap_state_e  state_q, state_d;
  logic [31:0] adr_q, adr_d, base, head;
  logic        vs_prev_q, vs_prev_d, cyc_q, cyc_d;
  logic        eof_q, eof_d, ov_q, ov_d, sint_q, sint_d;
  logic        vs, bl, vs_edge, act, ack, err, capt, drain;
  logic        push, push_ok, pop, fifo_clr, full, empty;
  logic [CW-1:0] cnt;

  assign base    = {CBAR, 2'b00};
  assign vs      = vsync_i ^ ctrl_vsl;
  assign bl      = blank_i ^ ctrl_bl;
  assign vs_edge = pix_en_i & vs & ~vs_prev_q;
  assign act     = pix_en_i & ~bl & ~vs;
  assign capt    = (state_q == ST_CAPT);
  assign drain   = (state_q == ST_DRAIN);

  // Error wins over a simultaneous ack: the word is neither popped nor counted.
  assign err      = cyc_q & wbm_err_i;
  assign ack      = cyc_q & wbm_ack_i & ~wbm_err_i;
  assign pop      = ack;
  assign push     = capt & act & ~err;
  assign push_ok  = push & (~full | pop);
  assign fifo_clr = wb_rst_i | err | (state_q == ST_ERROR);

  vga_capture_fifo #(.DW(PIX_W), .AW(FIFO_AWIDTH)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (rst_i),
    .clr_i   (fifo_clr),
    .push_i  (push_ok),
    .pop_i   (pop),
    .dat_i   (pix_word(rgb_i)),
    .dat_o   (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    cyc_d     = cyc_q;
    eof_d     = 1'b0;
    sint_d    = 1'b0;
    ov_d      = act & ~err & ((capt & ~push_ok) | drain);
    vs_prev_d = pix_en_i ? vs : vs_prev_q;

    case (state_q)
      ST_IDLE: if (ctrl_cen) begin
        state_d = ST_ARM;
        adr_d   = base;
      end
      ST_ARM: begin
        if (!ctrl_cen) state_d = ST_DRAIN;
        else if (vs_edge) begin
          state_d = ST_CAPT;
          adr_d   = base;
        end
      end
      ST_CAPT:  if (!ctrl_cen || vs_edge) state_d = ST_DRAIN;
      ST_DRAIN: if (empty && !cyc_q) begin
        eof_d   = 1'b1;
        adr_d   = base;
        state_d = (ctrl_csm || !ctrl_cen) ? ST_IDLE : ST_CAPT;
      end
      ST_ERROR: if (!ctrl_cen) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Bus master: cycle stays open while the FIFO will still hold data.
    if (capt || drain) begin
      if (err) begin
        state_d = ST_ERROR;
        cyc_d   = 1'b0;
        sint_d  = 1'b1;
      end else if (ack) begin
        adr_d = adr_q + 32'd4;
        cyc_d = (cnt > CW'(1)) | push_ok;
      end else if (!cyc_q) begin
        cyc_d = ~empty;
      end
    end else begin
      cyc_d = 1'b0;
    end

    if (wb_rst_i) begin
      state_d   = ST_IDLE;
      adr_d     = '0;
      cyc_d     = 1'b0;
      eof_d     = 1'b0;
      ov_d      = 1'b0;
      sint_d    = 1'b0;
      vs_prev_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge rst_i) begin
    if (rst_i == ARST_LVL) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      cyc_q     <= 1'b0;
      eof_q     <= 1'b0;
      ov_q      <= 1'b0;
      sint_q    <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      cyc_q     <= cyc_d;
      eof_q     <= eof_d;
      ov_q      <= ov_d;
      sint_q    <= sint_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = head;
  assign wbm_sel_o = 4'hf;
  assign wbm_we_o  = 1'b1;
  assign wbm_stb_o = cyc_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_cab_o = cyc_q;
  assign stat_busy = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign eof       = eof_q;
  assign ovint     = ov_q;
  assign sint      = sint_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: pixel stream driver, Wishbone slave model and a
// scoreboard of expected writes derived from the pixels each frame should keep.
module tb_vga_capture;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1, wb_rst_i = 1'b0;
  logic        cen = 1'b0, csm = 1'b0, vsl = 1'b0, bl_pol = 1'b0;
  logic [29:0] cbar = '0;
  logic        pix_en = 1'b0, vsync = 1'b0, blank = 1'b0;
  logic [23:0] rgb = '0;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, stb, cyc, cab, ack, err, busy, eof, ovint, sint;
  logic        ack_en = 1'b1, err_arm = 1'b0;
  int          beats = 0, beats_q = 0, err_base = 0;
  int          checks = 0, errors = 0, mon_checks = 0, mon_errors = 0;
  int          eof_cnt = 0, ov_cnt = 0, sint_cnt = 0;
  logic [31:0] exp_adr[$], exp_dat[$];
  logic [31:0] e_a, e_d, stall_adr, stall_dat;
  logic        err_seen = 1'b0, stall_prev = 1'b0;

  vga_capture dut (
    .wb_clk_i(clk), .rst_i(rst_i), .wb_rst_i(wb_rst_i),
    .ctrl_cen(cen), .ctrl_csm(csm), .ctrl_vsl(vsl), .ctrl_bl(bl_pol), .CBAR(cbar),
    .pix_en_i(pix_en), .vsync_i(vsync), .blank_i(blank), .rgb_i(rgb),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_cab_o(cab),
    .wbm_ack_i(ack), .wbm_err_i(err),
    .stat_busy(busy), .eof(eof), .ovint(ovint), .sint(sint)
  );

  always #5 clk = ~clk;

  // Slave: zero-wait ack when enabled; optional error on the third beat.
  assign err = cyc & stb & err_arm & ((beats_q - err_base) == 2);
  assign ack = cyc & stb & ack_en & ~err;

  always @(posedge clk) begin
    #1;
    beats_q = beats;
  end

  always @(negedge clk) begin
    if (err_seen) begin
      mon_checks++;
      if (cyc !== 1'b0 || stb !== 1'b0) begin
        mon_errors++;
        $display("FAIL cyc_after_err got cyc=%b stb=%b exp 0", cyc, stb);
      end
    end
    err_seen = cyc & stb & err;
    if (stall_prev && stb === 1'b1) begin
      mon_checks++;
      if (adr !== stall_adr || dat !== stall_dat) begin
        mon_errors++;
        $display("FAIL stall_hold got %h/%h exp %h/%h", adr, dat, stall_adr, stall_dat);
      end
    end
    stall_prev = stb & ~ack;
    stall_adr  = adr;
    stall_dat  = dat;
    if (cyc & stb & ack) begin
      beats++;
      mon_checks++;
      if (exp_adr.size() == 0) begin
        mon_errors++;
        $display("FAIL unexpected_write got adr=%h dat=%h exp none", adr, dat);
      end else begin
        e_a = exp_adr.pop_front();
        e_d = exp_dat.pop_front();
        if (adr !== e_a || dat !== e_d) begin
          mon_errors++;
          $display("FAIL write got adr=%h dat=%h exp adr=%h dat=%h", adr, dat, e_a, e_d);
        end
      end
    end
    if (eof === 1'b1)   eof_cnt++;
    if (ovint === 1'b1) ov_cnt++;
    if (sint === 1'b1)  sint_cnt++;
  end

  task automatic pix(input logic v, input logic b, input logic [23:0] c);
    pix_en = 1'b1; vsync = v ^ vsl; blank = b ^ bl_pol; rgb = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    pix_en = 1'b0; rgb = 24'($urandom);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic vpulse(input int nblank);
    pix(1'b0, 1'b1, 24'h0); pix(1'b1, 1'b1, 24'h0); pix(1'b1, 1'b1, 24'h0);
    for (int i = 0; i < nblank; i++) pix(1'b0, 1'b1, 24'h0);
  endtask

  // Model: the first 'keep' active pixels of a frame land at base + 4*index.
  task automatic frame(input int lines, input int ppl, input bit incr, input bit gaps,
                       input int keep, inout logic [23:0] seq);
    logic [31:0] base;
    logic [23:0] c;
    int k;
    base = {cbar, 2'b00}; k = 0;
    for (int l = 0; l < lines; l++) begin
      pix(1'b0, 1'b1, 24'h0); pix(1'b0, 1'b1, 24'h0);
      for (int p = 0; p < ppl; p++) begin
        if (gaps) idle($urandom_range(0, 2));
        c = incr ? seq : 24'($urandom);
        seq = seq + 24'd1;
        if (k < keep) begin
          exp_adr.push_back(base + 32'(4 * k));
          exp_dat.push_back({8'h00, c});
        end
        k++;
        pix(1'b0, 1'b0, c);
      end
    end
  endtask

  // Emulates the register block clearing enable when the frame completes.
  task automatic wait_eof(input int budget, output bit got, output logic busy_at);
    got = 1'b0; busy_at = 1'bx;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (eof === 1'b1) begin got = 1'b1; busy_at = busy; cen = 1'b0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL rst_cyc got %b%b exp 00", cyc, stb); end
    checks++; if (adr !== 32'h0) begin errors++; $display("FAIL rst_adr got %h exp 0", adr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if ({eof, ovint, sint} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {eof, ovint, sint}); end
    rst_i = 1'b0;
    idle(3);
    checks++; if (busy !== 1'b0 || cyc !== 1'b0) begin errors++; $display("FAIL idle_after_rst got busy=%b cyc=%b exp 0", busy, cyc); end
    checks++; if (sel !== 4'hf || we !== 1'b1) begin errors++; $display("FAIL sel_we got %h/%b exp f/1", sel, we); end
  endtask

  task automatic run_basic(input string nm, input logic vp, input logic bp);
    logic [23:0] seq;
    bit got; logic b_at;
    int e0, o0, s0;
    vsl = vp; bl_pol = bp; cbar = 30'h0000_4000; csm = 1'b1; ack_en = 1'b1;
    e0 = eof_cnt; o0 = ov_cnt; s0 = sint_cnt; seq = 24'h1;
    pix(1'b0, 1'b1, 24'h0);
    cen = 1'b1; idle(2);
    vpulse(6);
    frame(4, 8, 1'b1, 1'b0, 32, seq);
    vpulse(0);
    wait_eof(300, got, b_at);
    checks++; if (!got) begin errors++; $display("FAIL %s_eof got none exp pulse", nm); end
    checks++; if (b_at !== 1'b0) begin errors++; $display("FAIL %s_busy_at_eof got %b exp 0", nm, b_at); end
    checks++; if (exp_adr.size() != 0) begin errors++; $display("FAIL %s_missing got %0d left exp 0", nm, exp_adr.size()); end
    checks++; if (eof_cnt - e0 != 1) begin errors++; $display("FAIL %s_eof_cnt got %0d exp 1", nm, eof_cnt - e0); end
    checks++; if (ov_cnt != o0 || sint_cnt != s0) begin errors++; $display("FAIL %s_irq got ov=%0d s=%0d exp 0", nm, ov_cnt - o0, sint_cnt - s0); end
    idle(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b exp 0", nm, busy); end
    vsl = 1'b0; bl_pol = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [23:0] seq;
    bit got; logic b_at;
    int o0;
    cbar = 30'h0000_1000; csm = 1'b1; ack_en = 1'b0; o0 = ov_cnt; seq = 24'h00AB00;
    cen = 1'b1; idle(2);
    vpulse(6);
    frame(1, 20, 1'b0, 1'b0, 16, seq);
    idle(14);
    checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL bp_stalled_cyc got %b exp 1", cyc); end
    checks++; if (adr !== 32'h0000_4000) begin errors++; $display("FAIL bp_stalled_adr got %h exp 4000", adr); end
    ack_en = 1'b1;
    vpulse(0);
    wait_eof(300, got, b_at);
    checks++; if (!got) begin errors++; $display("FAIL bp_eof got none exp pulse"); end
    checks++; if (ov_cnt - o0 != 4) begin errors++; $display("FAIL bp_ovint got %0d exp 4", ov_cnt - o0); end
    checks++; if (exp_adr.size() != 0) begin errors++; $display("FAIL bp_missing got %0d left exp 0", exp_adr.size()); end
  endtask

  task automatic test_bus_error();
    logic [23:0] seq;
    bit got; logic b_at;
    int e0, s0;
    cbar = 30'h0000_0100; csm = 1'b1; ack_en = 1'b1; seq = 24'h0;
    e0 = eof_cnt; s0 = sint_cnt; err_base = beats; err_arm = 1'b1;
    cen = 1'b1; idle(2);
    vpulse(6);
    frame(1, 8, 1'b0, 1'b0, 2, seq);
    vpulse(0);
    idle(4);
    checks++; if (sint_cnt - s0 != 1) begin errors++; $display("FAIL err_sint got %0d exp 1", sint_cnt - s0); end
    checks++; if (cyc !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_state got cyc=%b busy=%b exp 0 0", cyc, busy); end
    checks++; if (exp_adr.size() != 0 || eof_cnt != e0) begin errors++; $display("FAIL err_writes got %0d left eof=%0d exp 0", exp_adr.size(), eof_cnt - e0); end
    err_arm = 1'b0; cen = 1'b0; idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_idle got busy=%b exp 0", busy); end
    cen = 1'b1; idle(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_rearm got busy=%b exp 1", busy); end
    vpulse(6);
    frame(1, 5, 1'b0, 1'b1, 5, seq);
    vpulse(0);
    wait_eof(300, got, b_at);
    checks++; if (!got || exp_adr.size() != 0) begin errors++; $display("FAIL err_restart got eof=%0d left=%0d exp 1 0", got, exp_adr.size()); end
    checks++; if (sint_cnt - s0 != 1) begin errors++; $display("FAIL err_sint_once got %0d exp 1", sint_cnt - s0); end
  endtask

  task automatic test_continuous();
    logic [23:0] seq;
    bit got; logic b_at;
    int e0, o0;
    cbar = 30'h3FFF_FFFC; csm = 1'b0; ack_en = 1'b1; seq = 24'h0;
    e0 = eof_cnt; o0 = ov_cnt;
    cen = 1'b1; idle(2);
    vpulse(6);
    for (int f = 0; f < 3; f++) begin
      frame(2, $urandom_range(3, 6), 1'b0, 1'b1, 1000, seq);
      if (f == 2) csm = 1'b1;
      vpulse(f == 2 ? 0 : 6);
    end
    wait_eof(300, got, b_at);
    checks++; if (eof_cnt - e0 != 3) begin errors++; $display("FAIL cont_eof got %0d exp 3", eof_cnt - e0); end
    checks++; if (exp_adr.size() != 0) begin errors++; $display("FAIL cont_missing got %0d left exp 0", exp_adr.size()); end
    checks++; if (ov_cnt != o0) begin errors++; $display("FAIL cont_ovint got %0d exp 0", ov_cnt - o0); end
  endtask

  task automatic test_async_reset();
    int e0, s0;
    cbar = 30'h0000_0200; csm = 1'b1; ack_en = 1'b0; e0 = eof_cnt; s0 = sint_cnt;
    cen = 1'b1; idle(2);
    vpulse(6);
    for (int i = 0; i < 4; i++) pix(1'b0, 1'b0, 24'($urandom));
    idle(3);
    checks++; if (cyc !== 1'b1 || cab !== 1'b1) begin errors++; $display("FAIL ar_mid_burst got cyc=%b cab=%b exp 1 1", cyc, cab); end
    rst_i = 1'b1;
    #1;
    checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL ar_async_drop got %b%b exp 00", cyc, stb); end
    checks++; if (adr !== 32'h0) begin errors++; $display("FAIL ar_adr got %h exp 0", adr); end
    cen = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle(5);
    checks++; if (busy !== 1'b0 || cyc !== 1'b0) begin errors++; $display("FAIL ar_idle got busy=%b cyc=%b exp 0", busy, cyc); end
    checks++; if (eof_cnt != e0 || sint_cnt != s0) begin errors++; $display("FAIL ar_pulses got eof=%0d sint=%0d exp 0", eof_cnt - e0, sint_cnt - s0); end
    cen = 1'b1; idle(2);
    vpulse(6);
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b0, 24'($urandom));
    idle(3);
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0; cen = 1'b0;
    checks++; if (cyc !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sync_rst got cyc=%b busy=%b exp 0", cyc, busy); end
    idle(3);
    checks++; if (eof_cnt != e0 || busy !== 1'b0) begin errors++; $display("FAIL sync_rst_idle got eof=%0d busy=%b exp 0", eof_cnt - e0, busy); end
    ack_en = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    run_basic("basic", 1'b0, 1'b0);
    test_back_pressure();
    test_bus_error();
    test_continuous();
    run_basic("polarity", 1'b1, 1'b1);
    test_async_reset();
    idle(2);
    checks += mon_checks;
    errors += mon_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Video capture engine; the inverse of the display path. It samples an incoming pixel stream (hsync/vsync/blank/RGB) and writes active pixels to system memory as a Wishbone master.
- Each frame is stored linearly from a programmable base address.
- Sits beside the display controller. It is driven by the slave register block (enable, base, polarities) and returns interrupt pulses to it.
- Single clock domain: the pixel source is already synchronous to the system clock and qualified by a pixel-enable strobe.

Parameters:
- FIFO_AWIDTH, 4: log2 depth of the internal pixel FIFO (16 entries).
- ARST_LVL, 1'b1: active level of rst_i. Fixed active-high; not to be overridden.

Ports:
- wb_clk_i  in  1  system/Wishbone clock.
- rst_i  in  1  asynchronous reset, active-high.
- wb_rst_i  in  1  synchronous reset, active-high; same effect as rst_i.
- ctrl_cen  in  1  capture enable.
- ctrl_csm  in  1  single-shot mode: capture one frame, then stop.
- ctrl_vsl  in  1  vsync_i active-low when 1.
- ctrl_bl  in  1  blank_i active-low when 1.
- CBAR  in  30  capture base address [31:2].
- pix_en_i  in  1  pixel strobe; samples vsync_i, blank_i and rgb_i.
- vsync_i  in  1  vertical sync.
- blank_i  in  1  blanking.
- rgb_i  in  24  pixel {R,G,B}.
- wbm_adr_o  out  32  master address.
- wbm_dat_o  out  32  master write data, {8'h00, rgb}.
- wbm_sel_o  out  4  constant 4'hf.
- wbm_we_o  out  1  constant 1.
- wbm_stb_o  out  1  strobe.
- wbm_cyc_o  out  1  cycle.
- wbm_cab_o  out  1  burst indicator; equals wbm_cyc_o.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  bus error.
- stat_busy  out  1  capture active (state is not IDLE or ERROR).
- eof  out  1  one-cycle pulse: frame fully written to memory.
- ovint  out  1  one-cycle pulse: pixel dropped.
- sint  out  1  one-cycle pulse: bus error.

Behaviour:
- Reset (either reset):
  - State IDLE.
  - All pulses 0, cyc/stb 0.
  - wbm_adr_o = {CBAR,2'b00} is loaded on the first exit from IDLE; its reset value is 0.
  - FIFO empty.
- Internal signals:
  - vs = vsync_i ^ ctrl_vsl.
  - bl = blank_i ^ ctrl_bl.
  - vs_edge: rising edge of vs, detected on pix_en_i samples only (the previous vs is held in a register updated when pix_en_i=1).
- FSM:
  - IDLE: when ctrl_cen=1, go to ARM.
  - ARM: on vs_edge, load adr = {CBAR,00}, then go to CAPT.
  - CAPT:
    - On pix_en_i & ~bl & ~vs, push {8'h00, rgb_i}.
    - On vs_edge, go to DRAIN.
  - DRAIN:
    - Accept no pixels.
    - Once the FIFO is empty and no cycle is open: pulse eof, reload adr = {CBAR,00}.
    - Next state is IDLE if ctrl_csm=1 or ctrl_cen=0, else CAPT.
    - A vs_edge during DRAIN is ignored.
  - ERROR: entered on wbm_err_i.
    - Flush FIFO, drop cyc/stb, pulse sint.
    - Stay until ctrl_cen=0, then go to IDLE.
- ctrl_cen falling in ARM or CAPT: go to DRAIN. Data already in the FIFO is always written. After DRAIN, go to IDLE.
- Overrun: a qualifying pixel while the FIFO is full, or an active pixel (pix_en_i & ~bl & ~vs) arriving during DRAIN, is discarded and produces a one-cycle ovint pulse. Capture continues; the address does not advance for dropped pixels.
- Master (states CAPT, DRAIN):
  - cyc/stb are registered.
  - They assert the cycle after the FIFO becomes non-empty.
  - wbm_dat_o is the FIFO head (first-word-fall-through).
  - On ack: pop the FIFO and add 4 to adr (32-bit wrap, no saturation).
  - cyc/stb stay high if the next FIFO count (count − 1 + push) > 0; otherwise they drop the cycle after the ack.
  - Outputs must not change while stb=1 and ack=0.
- Push and pop in the same cycle with the FIFO full is legal: the count is unchanged and no overrun occurs.
- wbm_err_i takes priority over a simultaneous wbm_ack_i. The erroring word is not counted and adr does not advance.
- A reset in the middle of a cycle drops cyc/stb immediately (asynchronously for rst_i).

Decomposition:
- vga_defines.v: state encodings (IDLE, ARM, CAPT, DRAIN, ERROR) and the pixel word pad constant.
- One sub-module, vga_capture_fifo:
  - Single-clock synchronous FIFO, first-word-fall-through, parameterised width and depth.
  - Outputs full, empty and count.
  - Async reset plus synchronous clear.

Test Plan:
- Basic frame:
  - Setup: CBAR = 30'h0400_0000>>2 is not used; CBAR = 30'h0000_4000 (byte base 32'h0001_0000); cen=1; csm=1; 4 lines × 8 active pixels with rgb = incrementing 24'h000001..; immediate ack.
  - Expect 32 writes at 0x10000..0x1007C with data 32'h00000001..00000020, one eof pulse after the last ack, then stat_busy=0.
- Back-pressure:
  - Stimulus: ack withheld for 40 cycles while 20 pixels arrive on consecutive cycles.
  - Expect the first 16 stored and 4 ovint pulses; then 16 writes, with addresses contiguous.
- Bus error:
  - Stimulus: wbm_err_i on the 3rd beat.
  - Expect a sint pulse, cyc=0 the next cycle, FIFO empty, state ERROR.
  - Then cen=0 → IDLE; re-enable with the next vs_edge → writes restart at base.
- Continuous mode:
  - Stimulus: csm=0, three frames.
  - Expect three eof pulses, each frame starting at base.
- Polarity:
  - Stimulus: ctrl_vsl=1 and ctrl_bl=1 with inverted inputs.
  - Expect results identical to scenario 1.
- Asynchronous reset mid-burst:
  - Stimulus: rst_i asserted mid-burst.
  - Expect cyc/stb=0 without a clock edge; after release the state is IDLE with no eof/sint.
